// File: rtl/ws2812b_rx.sv
// WS2812B line decoder: 24-bit GRB words (MSB first), pixel and frame-latch strobes; WS2812B_RX_ERRCHK_EN adds pulse-width checks and a sticky err.
// Latency: 2-cycle din synchronizer, pixel_valid one cycle after the falling edge of bit 24, frame_done one cycle after the gap is recognised.
// Backpressure: none; outputs are strobes and the consumer must take each word in the cycle it is flagged.
module ws2812b_rx #(
    parameter int T_THRESH_CYC = 7,
    parameter int T_MIN_CYC    = 2,
    parameter int T_MAX_CYC    = 20,
    parameter int RESET_CYC    = 600,
    parameter int PIXELS       = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din,
    output logic [23:0]                 pixel_data,
    output logic [$clog2(PIXELS)-1:0]   pixel_index,
    output logic                        pixel_valid,
    output logic                        frame_done,
    output logic                        err
);
    localparam int PW = $clog2(PIXELS);
    localparam int LW = $clog2(RESET_CYC + 1);
    localparam int HW = $clog2(T_MAX_CYC + 2);
`ifdef WS2812B_RX_ERRCHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READY, HIGH, LOW} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic [LW-1:0]   r_lcnt;
    logic [HW-1:0]   r_hcnt;
    logic [4:0]      r_bit_cnt;
    logic [23:0]     r_word;
    logic [PW-1:0]   r_pcnt;
    logic            r_got_word;
    logic [23:0]     r_pixel_data;
    logic [PW-1:0]   r_pixel_index;
    logic            r_pixel_valid, r_frame_done;
    logic            w_din, w_rise, w_fall, w_gap, w_ovr, w_short, w_shift, w_bit;
    logic [23:0]     w_word;

    assign w_din   = r_sync[1];
    assign w_bit   = (r_hcnt >= HW'(T_THRESH_CYC));
    assign w_short = ERR_EN && (r_hcnt < HW'(T_MIN_CYC));
    assign w_shift = w_fall && !w_short;
    assign w_word  = {r_word[22:0], w_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
        end else begin
            r_sync  <= {r_sync[0], din};
            r_state <= w_state_nxt;
        end
    end

    // A gap in LOW wins over a rising edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_gap       = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_din && r_lcnt == LW'(RESET_CYC - 1)) w_state_nxt = READY;
            end
            READY: begin
                if (w_din) begin
                    w_state_nxt = HIGH;
                    w_rise      = 1'b1;
                end
            end
            HIGH: begin
                if (!w_din) begin
                    w_state_nxt = LOW;
                    w_fall      = 1'b1;
                end else if (ERR_EN && r_hcnt == HW'(T_MAX_CYC)) begin
                    w_state_nxt = IDLE;
                    w_ovr       = 1'b1;
                end
            end
            LOW: begin
                if (r_lcnt == LW'(RESET_CYC)) begin
                    w_state_nxt = READY;
                    w_gap       = 1'b1;
                end else if (w_din) begin
                    w_state_nxt = HIGH;
                    w_rise      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt        <= '0;
            r_hcnt        <= '0;
            r_bit_cnt     <= '0;
            r_word        <= '0;
            r_pcnt        <= '0;
            r_got_word    <= 1'b0;
            r_pixel_data  <= '0;
            r_pixel_index <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;

            if (w_rise)
                r_hcnt <= HW'(1);
            else if (r_state == HIGH && w_din && r_hcnt != HW'(T_MAX_CYC + 1))
                r_hcnt <= r_hcnt + HW'(1);

            // IDLE counts an unbroken low run; LOW counts time since the last falling edge.
            if (w_fall)
                r_lcnt <= LW'(1);
            else if (w_ovr)
                r_lcnt <= '0;
            else if (r_state == IDLE)
                r_lcnt <= w_din ? '0 : r_lcnt + LW'(1);
            else if (r_state == LOW && r_lcnt != LW'(RESET_CYC))
                r_lcnt <= r_lcnt + LW'(1);

            if (w_shift) begin
                if (r_bit_cnt == 5'd23) begin
                    r_pixel_data  <= w_word;
                    r_pixel_index <= r_pcnt;
                    r_pixel_valid <= 1'b1;
                    r_pcnt        <= (r_pcnt == PW'(PIXELS - 1)) ? '0 : r_pcnt + PW'(1);
                    r_got_word    <= 1'b1;
                    r_bit_cnt     <= '0;
                    r_word        <= '0;
                end else begin
                    r_word    <= w_word;
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end

            if (w_gap) begin
                r_frame_done <= (r_bit_cnt != 5'd0) || r_got_word;
                r_bit_cnt    <= '0;
                r_word       <= '0;
                r_pcnt       <= '0;
                r_got_word   <= 1'b0;
            end

            if (w_ovr) begin
                r_bit_cnt <= '0;
                r_word    <= '0;
            end
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_index = r_pixel_index;
    assign pixel_valid = r_pixel_valid;
    assign frame_done  = r_frame_done;

`ifdef WS2812B_RX_ERRCHK_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if ((w_fall && w_short) || w_ovr || (w_gap && r_bit_cnt != 5'd0))
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812b_rx.sv
// Bench for ws2812b_rx: pulse-level stimulus, a bit/word/frame model fed by the same calls, per-cycle strobe scoreboard.
module tb_ws2812b_rx;
`ifdef WS2812B_RX_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif
    localparam int T_THRESH = 7;
    localparam int T_MIN    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_index;
    logic        pixel_valid, frame_done, err;

    always #5 clk = ~clk;

    ws2812b_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_index (pixel_index),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .err         (err)
    );

    typedef struct packed {
        logic        is_frame;
        logic [23:0] d;
        logic [5:0]  i;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0, n_fail = 0, n_pv = 0, n_fd = 0;
    int          pv0, fd0;
    bit          m_armed;
    int          m_nbits, m_nwords, m_pidx;
    logic        m_err;
    logic [23:0] m_word;
    logic [23:0] last_d;
    logic [5:0]  last_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decoder model: acts on whole pulses and gaps rather than cycles.
    task automatic m_pulse(input int h);
        if (!m_armed) return;
        if (ERRCHK && h < T_MIN) begin
            m_err = 1'b1;
            return;
        end
        m_word = {m_word[22:0], (h >= T_THRESH)};
        m_nbits++;
        if (m_nbits == 24) begin
            q.push_back('{1'b0, m_word, 6'(m_pidx)});
            m_pidx   = (m_pidx + 1) % 64;
            m_nwords++;
            m_nbits  = 0;
            m_word   = '0;
        end
    endtask

    task automatic m_gap();
        if (m_armed && (m_nbits != 0 || m_nwords != 0)) q.push_back('{1'b1, 24'h0, 6'h0});
        if (ERRCHK && m_armed && m_nbits != 0) m_err = 1'b1;
        m_armed  = 1'b1;
        m_nbits  = 0;
        m_nwords = 0;
        m_pidx   = 0;
        m_word   = '0;
    endtask

    task automatic m_reset();
        check("queue_empty_at_reset", q.size(), 0);
        q.delete();
        m_armed  = 1'b0;
        m_nbits  = 0;
        m_nwords = 0;
        m_pidx   = 0;
        m_word   = '0;
        m_err    = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        m_pulse(h);
        din = 1'b1;
        wait_cyc(h);
        din = 1'b0;
        wait_cyc(l);
    endtask

    task automatic send_word(input logic [23:0] w, input int nbits);
        for (int b = nbits - 1; b >= 0; b--)
            if (w[b]) send_pulse(10, 5);
            else      send_pulse(5, 10);
    endtask

    task automatic gap();
        m_gap();
        din = 1'b0;
        wait_cyc(700);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_outputs", {pixel_data, pixel_index, pixel_valid, frame_done, err}, 0);
            last_d = '0;
            last_i = '0;
        end else begin
            check("strobe_exclusive", {31'd0, pixel_valid & frame_done}, 0);
            if (pixel_valid || frame_done) begin
                if (pixel_valid) n_pv++;
                if (frame_done)  n_fd++;
                if (q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got pv=%0b fd=%0b, expected none", pixel_valid, frame_done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("strobe_kind", {pixel_valid, frame_done}, e.is_frame ? 2'b01 : 2'b10);
                    if (!e.is_frame) begin
                        check("pixel_data", pixel_data, e.d);
                        check("pixel_index", pixel_index, e.i);
                        last_d = e.d;
                        last_i = e.i;
                    end
                end
            end else begin
                check("hold_data", pixel_data, last_d);
                check("hold_index", pixel_index, last_i);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        m_reset();
        wait_cyc(3);
        check("reset_data", pixel_data, 0);
        check("reset_strobes", {pixel_valid, frame_done, err}, 0);
        rst_n = 1'b1;

        // 1: single word after an initial low period
        gap();
        pv0 = n_pv;
        send_word(24'h00FF00, 24);
        gap();
        check("t1_pv_count", n_pv - pv0, 1);
        check("t1_data", pixel_data, 24'h00FF00);
        check("t1_index", pixel_index, 0);

        // 2: full frame of 64 words, then index restarts
        pv0 = n_pv; fd0 = n_fd;
        for (int k = 0; k < 64; k++) send_word(24'(k), 24);
        gap();
        check("t2_pv_count", n_pv - pv0, 64);
        check("t2_fd_count", n_fd - fd0, 1);
        check("t2_last_index", pixel_index, 63);
        send_word(24'h000042, 24);
        gap();
        check("t2_restart_index", pixel_index, 0);
        check("t2_restart_data", pixel_data, 24'h000042);

        // 3: partial word then gap
        pv0 = n_pv; fd0 = n_fd;
        send_word(24'h000ABC, 12);
        gap();
        check("t3_pv_count", n_pv - pv0, 0);
        check("t3_fd_count", n_fd - fd0, 1);
        check("t3_err", err, m_err);
        check("t3_err_lit", err, ERRCHK);

        // 4: reset released in the middle of a stream
        rst_n = 1'b0;
        m_reset();
        send_word(24'h00001F, 5);
        rst_n = 1'b1;
        pv0 = n_pv; fd0 = n_fd;
        send_word(24'h0FFFFF, 20);
        gap();
        check("t4_no_pv_before_gap", n_pv - pv0, 0);
        check("t4_no_fd_first_gap", n_fd - fd0, 0);
        send_word(24'h123456, 24);
        gap();
        check("t4_data", pixel_data, 24'h123456);
        check("t4_index", pixel_index, 0);

        // 5: one-cycle glitch between bits 12 and 13
        fd0 = n_fd;
        send_word(24'h000ABC, 12);
        send_pulse(1, 8);
        send_word(24'h000DEF, 12);
        gap();
        check("t5_data", pixel_data, ERRCHK ? 24'hABCDEF : 24'hABC6F7);
        check("t5_err", err, ERRCHK);
        check("t5_err_model", err, m_err);
        check("t5_fd_count", n_fd - fd0, 1);

        // 6: reset asserted inside bit 11, then clean restart
        send_word(24'h0003FF, 10);
        din = 1'b1;
        wait_cyc(3);
        rst_n = 1'b0;
        m_reset();
        wait_cyc(2);
        check("t6_rst_data", pixel_data, 0);
        check("t6_rst_flags", {pixel_index, pixel_valid, frame_done, err}, 0);
        din = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        gap();
        send_word(24'hA5A5A5, 24);
        gap();
        check("t6_data", pixel_data, 24'hA5A5A5);
        check("t6_index", pixel_index, 0);
        check("t6_err", err, 0);

        check("queue_empty_end", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
